pattern_bist: RTL and testbench

Self-test driver and response compactor for a single-output combinational gate under test (e.g. the 8-input reduction NOR gate cells). It sits on the DUT's other side: it generates the input vector each cycle, samples the DUT's 1-bit response combinationally in the same cycle, and folds the response into a 16-bit serial signature. A start/busy/done handshake wraps each session, and the final signature is compared against a golden value. It is the hardware counterpart of the software pattern-generation flow, for on-chip fault grading.

---
 rtl/pattern_bist.sv | 109 ++++++++++
 tb/tb_pattern_bist.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_bist.sv
// pattern_bist: BIST pattern driver and 16-bit serial signature compactor
// for a single-output combinational gate under test.
// Optional feature: define PATTERN_LFSR_EN to drive patterns from an 8-bit
// Galois LFSR (seed 8'h01) instead of the exhaustive binary counter.
module pattern_bist #(
    parameter int WIDTH     = 8,
    parameter int PAT_COUNT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      golden,
    input  logic             response,
    output logic [WIDTH-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature,
    output logic             pass
);

    localparam int IW = $clog2(PAT_COUNT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     index;
    logic              last;
    logic              fb;
    logic [WIDTH-1:0]  pat_first;
    logic [WIDTH-1:0]  pat_next;

    assign last = (index == IW'(PAT_COUNT - 1));
    assign fb   = signature[15] ^ response;

`ifdef PATTERN_LFSR_EN
    generate
        if (WIDTH != 8) begin : g_width_check
            $error("pattern_bist: PATTERN_LFSR_EN requires WIDTH == 8");
        end
    endgenerate

    assign pat_first = WIDTH'(1);
    assign pat_next  = {1'b0, pattern[WIDTH-1:1]} ^ (pattern[0] ? WIDTH'(8'hB8) : '0);
`else
    assign pat_first = '0;
    // pattern tracks the low bits of index, so the next pattern is index+1
    assign pat_next  = WIDTH'(index + 1'b1);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is ignored while RUN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        pass = done && (signature == golden);
    end

    // Pattern, index and signature datapath; frozen on the final RUN edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern   <= '0;
            signature <= '0;
            index     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pattern   <= pat_first;
                        signature <= 16'hFFFF;
                        index     <= '0;
                    end
                end
                RUN: begin
                    signature <= {signature[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                    index     <= index + 1'b1;
                    if (!last) begin
                        pattern <= pat_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_bist.sv
// Self-checking bench for pattern_bist: a 256-pattern (255 with
// PATTERN_LFSR_EN) instance driving a table-defined gate, and a
// single-pattern instance for the short-session corner cases.
module tb_pattern_bist;

`ifdef PATTERN_LFSR_EN
    localparam int BIG_N = 255;
`else
    localparam int BIG_N = 256;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_b = 1'b0;
    logic [15:0] golden_b = '0;
    logic        resp_b;
    logic [7:0]  pat_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] sig_b;

    logic        start_s = 1'b0;
    logic [15:0] golden_s = '0;
    logic        resp_s = 1'b0;
    logic [7:0]  pat_s;
    logic        busy_s, done_s, pass_s;
    logic [15:0] sig_s;

    logic [255:0] tt;          // truth table of the gate under test
    logic         fault = 1'b0; // stuck-at-0 on the gate output
    logic [7:0]   pats [BIG_N];

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    assign resp_b = fault ? 1'b0 : tt[pat_b];

    pattern_bist #(.WIDTH(8), .PAT_COUNT(BIG_N)) u_big (
        .clk(clk), .rst(rst), .start(start_b), .golden(golden_b),
        .response(resp_b), .pattern(pat_b), .busy(busy_b), .done(done_b),
        .signature(sig_b), .pass(pass_b)
    );

    pattern_bist #(.WIDTH(8), .PAT_COUNT(1)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .golden(golden_s),
        .response(resp_s), .pattern(pat_s), .busy(busy_s), .done(done_s),
        .signature(sig_s), .pass(pass_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC-CCITT style serial fold of one response bit
    function automatic logic [15:0] fold(input logic [15:0] s, input logic r);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16] ^ r) t[15:0] = t[15:0] ^ 16'h1021;
        return t[15:0];
    endfunction

    function automatic logic resp_model(input logic [7:0] p);
        return fault ? 1'b0 : tt[p];
    endfunction

    // One session on the big instance; optional ignored start pulse and abort by reset
    task automatic run_big(input string tag, input logic [15:0] gold,
                           input int unsigned poke_at, input int unsigned abort_at);
        logic [15:0] s;
        s = 16'hFFFF;
        golden_b = gold;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int unsigned i = 0; i < BIG_N; i++) begin
            if (i == abort_at) begin
                start_b = 1'b0;
                rst = 1'b1;
                #1;
                check({tag, ".rst_pat"},  32'(pat_b),  32'h0);
                check({tag, ".rst_sig"},  32'(sig_b),  32'h0);
                check({tag, ".rst_busy"}, 32'(busy_b), 32'h0);
                check({tag, ".rst_done"}, 32'(done_b), 32'h0);
                check({tag, ".rst_pass"}, 32'(pass_b), 32'h0);
                @(negedge clk); rst = 1'b0;
                return;
            end
            check({tag, ".pat"},  32'(pat_b),  32'(pats[i]));
            check({tag, ".busy"}, 32'(busy_b), 32'h1);
            check({tag, ".done"}, 32'(done_b), 32'h0);
            check({tag, ".sig"},  32'(sig_b),  32'(s));
            s = fold(s, resp_model(pats[i]));
            start_b = (i == poke_at);
            @(negedge clk);
        end
        start_b = 1'b0;
        check({tag, ".end_done"}, 32'(done_b), 32'h1);
        check({tag, ".end_busy"}, 32'(busy_b), 32'h0);
        check({tag, ".end_sig"},  32'(sig_b),  32'(s));
        check({tag, ".end_pass"}, 32'(pass_b), 32'(s == gold));
        check({tag, ".end_pat"},  32'(pat_b),  32'(pats[BIG_N-1]));
        @(negedge clk);
        check({tag, ".hold_done"}, 32'(done_b), 32'h1);
        check({tag, ".hold_sig"},  32'(sig_b),  32'(s));
        check({tag, ".hold_pat"},  32'(pat_b),  32'(pats[BIG_N-1]));
    endtask

    function automatic logic [15:0] model_sig();
        logic [15:0] s;
        s = 16'hFFFF;
        for (int unsigned i = 0; i < BIG_N; i++) s = fold(s, resp_model(pats[i]));
        return s;
    endfunction

    // Two-edge session on the single-pattern instance
    task automatic run_small(input string tag, input logic r, input logic [15:0] gold,
                             input logic [15:0] exp_sig, input logic exp_pass);
        resp_s = r;
        golden_s = gold;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        check({tag, ".busy"}, 32'(busy_s), 32'h1);
        check({tag, ".pat"},  32'(pat_s),  32'(pats[0]));
        @(negedge clk);
        check({tag, ".done"}, 32'(done_s), 32'h1);
        check({tag, ".busy0"}, 32'(busy_s), 32'h0);
        check({tag, ".sig"},  32'(sig_s),  32'(exp_sig));
        check({tag, ".pass"}, 32'(pass_s), 32'(exp_pass));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ref_sig;
        logic [7:0]  v;
        logic [255:0] nor_tt;

        // Expected pattern sequence derived from the sequence definition
        v = 8'h01;
        for (int unsigned i = 0; i < BIG_N; i++) begin
`ifdef PATTERN_LFSR_EN
            pats[i] = v;
            v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
`else
            pats[i] = 8'(i);
`endif
        end
        nor_tt = '0;
        nor_tt[0] = 1'b1;
        tt = nor_tt;

        repeat (2) @(negedge clk);
        check("reset.pat",  32'(pat_b),  32'h0);
        check("reset.sig",  32'(sig_b),  32'h0);
        check("reset.busy", 32'(busy_b), 32'h0);
        check("reset.done", 32'(done_b), 32'h0);
        check("reset.pass", 32'(pass_b), 32'h0);
        rst = 1'b0;

        // Single-pattern sessions
        run_small("s_r0", 1'b0, 16'hEFDF, 16'hEFDF, 1'b1);
        run_small("s_r1", 1'b1, 16'hEFDF, 16'hFFFE, 1'b0);

        // Start held: DONE lasts one cycle before restarting
        resp_s = 1'b0;
        @(negedge clk); start_s = 1'b1;
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clk);
            check("s_hold.busy", 32'(busy_s), 32'(c % 2 == 0));
            check("s_hold.done", 32'(done_s), 32'(c % 2 == 1));
        end
        start_s = 1'b0;

        // NOR gate, fault-free, with an ignored start pulse in RUN
        ref_sig = model_sig();
        run_big("nor", ref_sig, 40, BIG_N + 1);
        // Restart from DONE reproduces the signature
        run_big("nor_again", ref_sig, BIG_N + 1, BIG_N + 1);

        // Stuck-at-0 output against the fault-free golden
        fault = 1'b1;
        run_big("stuck0", ref_sig, BIG_N + 1, BIG_N + 1);
        fault = 1'b0;

        // Reset mid-RUN, then a full clean session
        run_big("abort", 16'h0000, BIG_N + 1, 100);
        run_big("after_abort", ref_sig, BIG_N + 1, BIG_N + 1);

        // Random truth tables, matching and random golden values
        for (int unsigned n = 0; n < 3; n++) begin
            for (int w = 0; w < 8; w++) tt[w*32 +: 32] = $urandom();
            ref_sig = model_sig();
            run_big("rand_match", ref_sig, $urandom_range(BIG_N - 2, 0), BIG_N + 1);
            run_big("rand_gold", 16'($urandom()), BIG_N + 1, BIG_N + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
